sccb_master: RTL and testbench
==============================

// Module: sccb_master
// PURPOSE
//  Executes 3-phase SCCB write cycles (device ID, register address, data) to the OV7670.
//  Sits directly downstream of ov7670_config, which supplies sccb_start, sccb_addr and sccb_data
//  and waits for sccb_done. Pad logic at the top level: siod = siod_oe ? siod_out : 1'bz.
// PARAMETERS
//  CLK_FREQ_HZ   100_000_000  system clock frequency
//  SCCB_FREQ_HZ  100_000      SIOC frequency
//  DEV_ID        8'h42        OV7670 write ID, sent as phase 1
//  QDIV          CLK_FREQ_HZ/(4*SCCB_FREQ_HZ)  quarter-bit period in clk cycles (derived localparam, >=1)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  sccb_start in   1  request; sampled only in IDLE
//  sccb_addr  in   8  register address; latched on accept
//  sccb_data  in   8  register data; latched on accept
//  sccb_done  out  1  one-cycle pulse after the STOP completes
//  busy       out  1  high from the accept cycle through the sccb_done cycle
//  ack_err    out  1  sticky per transaction: a 9th bit was sampled high; valid at sccb_done
//  sioc       out  1  SCCB clock
//  siod_out   out  1  SIOD drive value
//  siod_oe    out  1  SIOD output enable (0 = released during 9th bits)
//  siod_in    in   1  SIOD pad readback
// BEHAVIOUR
//  Clock and reset:
//  - Single clock, clk. rst is synchronous and active-high.
//  - Reset values: sioc=1, siod_out=1, siod_oe=1, busy=0, sccb_done=0, ack_err=0, state=IDLE.
//  - rst mid-transaction aborts immediately; outputs take reset values on the next edge. No STOP is generated.
//  Timing:
//  - A quarter counter counts 0..QDIV-1. Each slot is 4 quarters, q0..q3.
//  - The FSM advances only on a quarter-counter wrap.
//  FSM: IDLE -> START -> BITS -> STOP -> DONE -> IDLE.
//  - IDLE: sioc=1, siod_out=1, siod_oe=1.
//    - If sccb_start=1: latch a 27-bit shift register {DEV_ID,1'bx, sccb_addr,1'bx, sccb_data,1'bx},
//      clear ack_err, set busy=1, clear the quarter counter, go to START.
//  - START (1 slot): sioc=1 throughout. siod_out=1 in q0..q1, 0 in q2..q3 (SIOD falls while SIOC high).
//  - BITS (27 slots, MSB first, bit index 0..26):
//    - q0..q1: sioc=0. q2..q3: sioc=1.
//    - siod_out updates at the start of q0 only; it is stable while sioc=1.
//    - Index 8, 17 and 26 (the 9th bit of each phase): siod_oe=0.
//      At the end of q2, sample siod_in; if it is 1, set ack_err=1.
//    - All other bits: siod_oe=1.
//  - STOP (1 slot): siod_oe=1, siod_out=0.
//    - sioc=0 in q0..q1 and 1 in q2..q3.
//    - siod_out rises to 1 at q3 (SIOD rises while SIOC high).
//  - DONE (1 clk): sccb_done=1, busy=1; next state IDLE.
//  Latency:
//  - Accept edge to sccb_done=1 is exactly 116*QDIV+1 clk cycles.
//  - sccb_done is never asserted outside DONE.
//  Handshake rules:
//  - sccb_start while busy=1 (including the DONE cycle) is ignored; it is not queued.
//  - sccb_start held high re-triggers in the IDLE cycle after DONE.
//  - sccb_addr and sccb_data may change after the accept cycle without effect.
//  - ack_err never aborts a transfer (SCCB 9th bit is don't-care); it is informational only.
// TESTING (CLK_FREQ_HZ=4_000_000, SCCB_FREQ_HZ=100_000 -> QDIV=10)
//  1. rst=1 for 2 cycles, then idle 50 cycles -> sioc=1, siod_out=1, siod_oe=1, busy=0, sccb_done=0 throughout.
//  2. Start with addr=8'h12, data=8'h80; model ACKs (drives 0) on 9th bits
//     -> bits on SIOC rising edges are 0x42,x,0x12,x,0x80,x; sccb_done pulses once at 1161 cycles;
//     ack_err=0; START/STOP edge relations hold.
//  3. Same write with the model leaving SIOD released (pull-up 1) -> ack_err=1 at sccb_done;
//     the transfer still completes with the same timing.
//  4. Pulse sccb_start with addr=8'h3A at cycle 300 of a running transfer
//     -> ignored; only the original addr appears on the bus; exactly one sccb_done.
//  5. Hold sccb_start=1 with two successive addr/data pairs (8'h11/8'h01, 8'h0C/8'h04)
//     -> second START begins 1 cycle after the first sccb_done; two sccb_done pulses 1162 cycles apart.
//  6. rst=1 at cycle 600 of a transfer -> next edge: sioc=1, siod_out=1, siod_oe=1, busy=0; no sccb_done;
//     a new start then completes normally.

Source files
------------

// File: rtl/sccb_master.sv
// sccb_master: SCCB (I2C-like) three-phase write engine for the OV7670.
// Sends {DEV_ID, x, addr, x, data, x} MSB first between a START and a STOP.
// Each bit slot is four quarter periods. SIOC is low in q0..q1 and high in
// q2..q3. SIOD changes only at the start of q0.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   sccb_start           request, accepted only while idle
//   sccb_addr/sccb_data  register address/data, latched on accept
//   sccb_done            one-cycle pulse after the STOP
//   busy                 high from accept through the sccb_done cycle
//   ack_err              a 9th bit was read high during this transaction
//   sioc                 SCCB clock
//   siod_out, siod_oe    SIOD drive value and enable (released on 9th bits)
//   siod_in              SIOD pad readback
//
// state | meaning
// IDLE  | bus idle (SIOC=SIOD=1), waiting for sccb_start
// START | one slot; SIOD falls at q2 while SIOC is high
// BITS  | 27 data slots, 3 phases of 8 bits + released 9th bit
// STOP  | one slot; SIOD rises at q3 while SIOC is high
// DONE  | one clk; sccb_done pulse
module sccb_master #(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ID       = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sccb_start,
  input  logic [7:0] sccb_addr,
  input  logic [7:0] sccb_data,
  output logic       sccb_done,
  output logic       busy,
  output logic       ack_err,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe,
  input  logic       siod_in
);

  localparam int unsigned QDIV_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
  localparam int unsigned QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST  = QW'(QDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [4:0]    bit_q, bit_d;
  logic [26:0]   shreg_q, shreg_d;
  logic          ack_err_q, ack_err_d;

  logic qwrap;
  logic slot_end;
  logic accept;
  logic ninth;

  assign qwrap    = (qcnt_q == QLAST);
  assign slot_end = qwrap && (qtr_q == 2'd3);
  assign accept   = (state_q == S_IDLE) && sccb_start;
  assign ninth    = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sccb_start) state_d = S_START;
      S_START: if (slot_end) state_d = S_BITS;
      S_BITS:  if (slot_end && (bit_q == 5'd26)) state_d = S_STOP;
      S_STOP:  if (slot_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Quarter timer, bit index, shift register and ack flag
  always_comb begin
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    ack_err_d = ack_err_q;
    if (accept) begin
      qcnt_d    = '0;
      qtr_d     = 2'd0;
      bit_d     = 5'd0;
      // The 9th-bit positions are don't-care; they are released on the bus.
      shreg_d   = {DEV_ID, 1'b1, sccb_addr, 1'b1, sccb_data, 1'b1};
      ack_err_d = 1'b0;
    end else if (state_q inside {S_START, S_BITS, S_STOP}) begin
      qcnt_d = qwrap ? '0 : qcnt_q + 1'b1;
      if (qwrap) begin
        qtr_d = qtr_q + 2'd1;
      end
      if ((state_q == S_BITS) && qwrap) begin
        // End of q2 on a released bit: the slave should be pulling low.
        if ((qtr_q == 2'd2) && ninth && siod_in) begin
          ack_err_d = 1'b1;
        end
        // Shifting at the slot end makes SIOD change at the start of q0.
        if (qtr_q == 2'd3) begin
          bit_d   = bit_q + 5'd1;
          shreg_d = {shreg_q[25:0], 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt_q    <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 5'd0;
      shreg_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Output logic
  always_comb begin
    sioc      = 1'b1;
    siod_out  = 1'b1;
    siod_oe   = 1'b1;
    busy      = 1'b1;
    sccb_done = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: siod_out = ~qtr_q[1];
      S_BITS: begin
        sioc     = qtr_q[1];
        siod_out = shreg_q[26];
        siod_oe  = ~ninth;
      end
      S_STOP: begin
        sioc     = qtr_q[1];
        siod_out = (qtr_q == 2'd3);
      end
      S_DONE:  sccb_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_sccb_master.sv
module tb_sccb_master;

  localparam int Q  = 10;
  localparam int TQ = 116 * Q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sccb_start = 1'b0;
  logic [7:0] sccb_addr = 8'h00;
  logic [7:0] sccb_data = 8'h00;
  logic       sccb_done, busy, ack_err, sioc, siod_out, siod_oe;
  logic       siod_in;
  logic       slave_drv = 1'b0;
  int         slave_mode = 0;

  assign siod_in = siod_oe ? siod_out : slave_drv;

  always #5 clk = ~clk;

  sccb_master #(
    .CLK_FREQ_HZ (4_000_000),
    .SCCB_FREQ_HZ(100_000),
    .DEV_ID      (8'h42)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sccb_start(sccb_start),
    .sccb_addr (sccb_addr),
    .sccb_data (sccb_data),
    .sccb_done (sccb_done),
    .busy      (busy),
    .ack_err   (ack_err),
    .sioc      (sioc),
    .siod_out  (siod_out),
    .siod_oe   (siod_oe),
    .siod_in   (siod_in)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Slave: drives the released 9th bits (0 = ACK, 1 = released high, 2 = random).
  always @(posedge clk) begin
    #2;
    case (slave_mode)
      0:       slave_drv = 1'b0;
      1:       slave_drv = 1'b1;
      default: slave_drv = 1'($urandom_range(0, 1));
    endcase
  end

  // Behavioural model: m_t counts clk edges since the accept edge.
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [26:0] m_bits = '0;
  logic        m_ack = 1'b0;

  always @(posedge clk) begin
    if (rst) m_act = 1'b0;
    else if (m_act) begin
      if (m_t == TQ) m_act = 1'b0;
      else m_t++;
    end else if (sccb_start) begin
      m_act  = 1'b1;
      m_t    = 0;
      m_bits = {8'h42, 1'b1, sccb_addr, 1'b1, sccb_data, 1'b1};
      m_ack  = 1'b0;
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin : cmp
    int slot, qtr, b;
    logic e_sioc, e_out, e_oe;
    if (!m_act) begin
      chk("idle_sioc", sioc, 1);
      chk("idle_siod_out", siod_out, 1);
      chk("idle_siod_oe", siod_oe, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", sccb_done, 0);
    end else if (m_t == TQ) begin
      chk("done_pulse", sccb_done, 1);
      chk("done_busy", busy, 1);
      chk("done_ack_err", ack_err, m_ack);
    end else begin
      slot = m_t / (4 * Q);
      qtr  = (m_t / Q) % 4;
      if (slot == 0) begin
        e_sioc = 1'b1; e_out = (qtr < 2); e_oe = 1'b1;
      end else if (slot <= 27) begin
        b      = slot - 1;
        e_sioc = (qtr >= 2);
        e_oe   = ((b % 9) != 8);
        e_out  = m_bits[26-b];
        if (!e_oe && qtr == 2 && (m_t % Q) == Q - 1) m_ack = m_ack | siod_in;
      end else begin
        e_sioc = (qtr >= 2); e_out = (qtr == 3); e_oe = 1'b1;
      end
      chk("xfer_busy", busy, 1);
      chk("xfer_done", sccb_done, 0);
      chk("xfer_sioc", sioc, e_sioc);
      chk("xfer_siod_oe", siod_oe, e_oe);
      if (e_oe) chk("xfer_siod_out", siod_out, e_out);
    end
  end

  // Bus monitor: pad value on every SIOC rising edge of a transaction.
  logic [27:0] cap = '0;
  int          nrise = 0;
  int          done_cnt = 0;

  always @(posedge busy) begin
    cap = '0;
    nrise = 0;
  end
  always @(posedge sioc) if (busy === 1'b1) begin
    cap = {cap[26:0], siod_in};
    nrise++;
  end
  always @(negedge clk) if (sccb_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a write and returns in the sccb_done cycle with the edge count
  // from raising sccb_start. intr_at >= 0 pulses a foreign request then.
  task automatic run_write(input logic [7:0] a, input logic [7:0] d, input int mode,
                           input int intr_at, output int lat);
    slave_mode = mode;
    sccb_addr  = a;
    sccb_data  = d;
    sccb_start = 1'b1;
    tick();
    lat = 1;
    sccb_start = 1'b0;
    sccb_addr  = 8'($urandom);
    sccb_data  = 8'($urandom);
    while (sccb_done !== 1'b1 && lat < 3000) begin
      if (lat == intr_at) begin
        sccb_start = 1'b1;
        sccb_addr  = 8'h3A;
      end else sccb_start = 1'b0;
      tick();
      lat++;
    end
    sccb_start = 1'b0;
  endtask

  task automatic check_bus(input string name, input logic [7:0] a, input logic [7:0] d);
    logic [26:0] mask, expv;
    mask = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    expv = {8'h42, 1'b0, a, 1'b0, d, 1'b0};
    chk({name, "_rises"}, nrise, 28);
    chk({name, "_bits"}, cap[27:1] & mask, expv);
    chk({name, "_stop_bit"}, cap[0], 0);
  endtask

  task automatic full_write(input string name, input logic [7:0] a, input logic [7:0] d,
                            input int mode);
    int lat;
    run_write(a, d, mode, -1, lat);
    chk({name, "_latency"}, lat, 1161);
    if (mode < 2) chk({name, "_ack_err"}, ack_err, (mode == 1) ? 1 : 0);
    check_bus(name, a, d);
    tick();
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, gap, d0;
    // 1: reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_sioc", sioc, 1);
    chk("rst_ack_err", ack_err, 0);
    repeat (50) tick();

    // 2: ACKed write
    full_write("ack_write", 8'h12, 8'h80, 0);
    // 3: slave leaves SIOD released
    full_write("nack_write", 8'h12, 8'h80, 1);

    // 4: foreign request mid-transfer is ignored
    repeat (5) tick();
    d0 = done_cnt;
    run_write(8'h5C, 8'hA7, 0, 300, lat);
    chk("ignore_latency", lat, 1161);
    check_bus("ignore", 8'h5C, 8'hA7);
    repeat (3) tick();
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_busy_after", busy, 0);

    // 5: sccb_start held high, back-to-back writes
    repeat (4) tick();
    slave_mode = 0;
    sccb_addr  = 8'h11;
    sccb_data  = 8'h01;
    sccb_start = 1'b1;
    tick();
    lat = 1;
    while (sccb_done !== 1'b1 && lat < 3000) begin
      tick();
      lat++;
    end
    chk("held_first_latency", lat, 1161);
    check_bus("held_first", 8'h11, 8'h01);
    sccb_addr = 8'h0C;
    sccb_data = 8'h04;
    tick();
    gap = 1;
    chk("held_idle_gap_busy", busy, 0);
    tick();
    gap = 2;
    sccb_start = 1'b0;
    chk("held_second_busy", busy, 1);
    while (sccb_done !== 1'b1 && gap < 3000) begin
      tick();
      gap++;
    end
    chk("held_done_spacing", gap, 1162);
    check_bus("held_second", 8'h0C, 8'h04);
    tick();

    // 6: reset mid-transfer
    repeat (3) tick();
    slave_mode = 0;
    sccb_addr  = 8'h55;
    sccb_data  = 8'h66;
    sccb_start = 1'b1;
    tick();
    sccb_start = 1'b0;
    repeat (599) tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_sioc", sioc, 1);
    chk("abort_siod_out", siod_out, 1);
    chk("abort_siod_oe", siod_oe, 1);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (1300) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    full_write("after_abort", 8'h3E, 8'hC9, 0);

    // Random writes
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 20)) tick();
      full_write("rand_write", 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
